// File: rtl/enemy_health_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : enemy_health_ctrl                                          |
// | Description : Enemy hit-point owner and health-bar producer. Accepts     |
// |               damage through a valid/ready handshake. Recomputes the bar |
// |               target width with a multicycle restoring divider. Drains   |
// |               the displayed width toward the target once per frame.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk_in         system clock                                            |
// |   rst_in         synchronous reset, active-low                           |
// |   new_enemy_in   spawn / refill pulse (highest priority)                 |
// |   dmg_valid_in   damage request valid                                    |
// |   dmg_amount_in  damage amount, unsigned                                 |
// |   dmg_ready_out  damage can be accepted this cycle                       |
// |   frame_tick_in  one pulse per video frame                               |
// |   valid_out      bar visible (renderer valid_in)                         |
// |   border_out     displayed fill width in pixels (renderer border_in)     |
// |   hp_out         current hit points                                      |
// |   defeated_out   one-cycle pulse once the bar has drained to zero        |
// +--------------------------------------------------------------------------+
// | Build option : LOW_HP_BLINK_EN - blink the bar every 16 frames while     |
// |                hp*4 <= MAX_HP in ALIVE/CALC.                             |
// +--------------------------------------------------------------------------+
module enemy_health_ctrl #(
   parameter int MAX_HP     = 100,
   parameter int HP_W       = 8,
   parameter int WIDTH      = 96,
   parameter int DRAIN_STEP = 1
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            new_enemy_in,
   input  logic            dmg_valid_in,
   input  logic [HP_W-1:0] dmg_amount_in,
   output logic            dmg_ready_out,
   input  logic            frame_tick_in,
   output logic            valid_out,
   output logic [10:0]     border_out,
   output logic [HP_W-1:0] hp_out,
   output logic            defeated_out
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ALIVE = 3'd1;
   localparam logic [2:0] S_CALC  = 3'd2;
   localparam logic [2:0] S_DYING = 3'd3;
   localparam logic [2:0] S_DEAD  = 3'd4;

   localparam int PW = HP_W + 11;

   localparam logic [HP_W-1:0] C_MAX_HP  = HP_W'(MAX_HP);
   localparam logic [HP_W:0]   C_DIVISOR = (HP_W+1)'(MAX_HP);
   localparam logic [10:0]     C_WIDTH   = 11'(WIDTH);
   localparam logic [10:0]     C_STEP    = 11'(DRAIN_STEP);
   localparam logic [3:0]      C_LAST    = 4'd11;

   logic [2:0]      state_q, state_d;
   logic [HP_W-1:0] hp_q, hp_d;
   logic [10:0]     border_q, border_d;
   logic [10:0]     target_q, target_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [HP_W-1:0] rem_q, rem_d;
   logic [10:0]     dvd_q, dvd_d;
   logic [10:0]     quot_q, quot_d;
   logic            defeated_q, defeated_d;

   logic [PW-1:0]   w_prod;
   logic [HP_W:0]   w_trial;
   logic            w_qbit;
   logic [HP_W:0]   w_trial_sub;
   logic [HP_W-1:0] w_hp_sub;
   logic [10:0]     w_gap;
   logic [10:0]     w_border_tick;
   logic            w_accept;
   logic            w_drain;

   // -------------------------------------------------------------------
   // Datapath helpers
   // -------------------------------------------------------------------
   // hp <= MAX_HP bounds the quotient below 2^11, so the upper HP_W bits of
   // the product are already a valid partial remainder (< MAX_HP) and only
   // the low 11 dividend bits need to be shifted in.
   assign w_prod      = PW'(hp_q) * PW'(C_WIDTH);
   assign w_trial     = {rem_q, dvd_q[10]};
   assign w_qbit      = (w_trial >= C_DIVISOR);
   assign w_trial_sub = w_trial - C_DIVISOR;
   assign w_hp_sub    = (hp_q > dmg_amount_in) ? (hp_q - dmg_amount_in) : '0;
   assign w_accept    = dmg_valid_in && dmg_ready_out;
   assign w_drain     = frame_tick_in &&
                        ((state_q == S_ALIVE) || (state_q == S_CALC) || (state_q == S_DYING));

   // Drain moves down by at most DRAIN_STEP without overshooting; a target
   // above the displayed width is taken immediately.
   always_comb begin
      w_gap         = border_q - target_q;
      w_border_tick = border_q;
      if (border_q > target_q) begin
         w_border_tick = border_q - ((w_gap < C_STEP) ? w_gap : C_STEP);
      end else if (border_q < target_q) begin
         w_border_tick = target_q;
      end
   end

   // -------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q    <= S_IDLE;
         hp_q       <= '0;
         border_q   <= '0;
         target_q   <= '0;
         cnt_q      <= '0;
         rem_q      <= '0;
         dvd_q      <= '0;
         quot_q     <= '0;
         defeated_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hp_q       <= hp_d;
         border_q   <= border_d;
         target_q   <= target_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         dvd_q      <= dvd_d;
         quot_q     <= quot_d;
         defeated_q <= defeated_d;
      end
   end

   // -------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      hp_d       = hp_q;
      border_d   = border_q;
      target_d   = target_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      dvd_d      = dvd_q;
      quot_d     = quot_q;
      defeated_d = 1'b0;

      if (new_enemy_in) begin
         // Spawn wins everywhere; a concurrent handshake is dropped.
         state_d  = S_ALIVE;
         hp_d     = C_MAX_HP;
         target_d = C_WIDTH;
         border_d = C_WIDTH;
         cnt_d    = '0;
      end else begin
         if (w_drain) begin
            border_d = w_border_tick;
         end
         case (state_q)
            S_ALIVE: begin
               if (w_accept) begin
                  hp_d    = w_hp_sub;
                  state_d = S_CALC;
                  cnt_d   = '0;
               end
            end
            S_CALC: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd0) begin
                  rem_d  = w_prod[PW-1:11];
                  dvd_d  = w_prod[10:0];
                  quot_d = '0;
               end else begin
                  rem_d  = w_qbit ? w_trial_sub[HP_W-1:0] : w_trial[HP_W-1:0];
                  dvd_d  = {dvd_q[9:0], 1'b0};
                  quot_d = {quot_q[9:0], w_qbit};
                  if (cnt_q == C_LAST) begin
                     target_d = {quot_q[9:0], w_qbit};
                     state_d  = (hp_q != '0) ? S_ALIVE : S_DYING;
                  end
               end
            end
            S_DYING: begin
               if (frame_tick_in && (w_border_tick == 11'd0)) begin
                  state_d    = S_DEAD;
                  defeated_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------
   // Optional low-HP blink
   // -------------------------------------------------------------------
`ifdef LOW_HP_BLINK_EN
   logic [3:0] fcnt_q, fcnt_d;
   logic       blink_q, blink_d;
   logic       w_low_hp;

   assign w_low_hp = ({2'b00, hp_q} << 2) <= (HP_W+2)'(MAX_HP);

   always_comb begin
      fcnt_d  = fcnt_q;
      blink_d = blink_q;
      if (new_enemy_in) begin
         fcnt_d  = '0;
         blink_d = 1'b1;
      end else if ((state_q != S_DYING) && (state_d == S_DYING)) begin
         blink_d = 1'b1;
      end else if (frame_tick_in && w_low_hp &&
                   ((state_q == S_ALIVE) || (state_q == S_CALC))) begin
         fcnt_d = fcnt_q + 4'd1;
         if (fcnt_q == 4'hF) begin
            blink_d = ~blink_q;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         fcnt_q  <= '0;
         blink_q <= 1'b1;
      end else begin
         fcnt_q  <= fcnt_d;
         blink_q <= blink_d;
      end
   end
`endif

   // -------------------------------------------------------------------
   // Output logic
   // -------------------------------------------------------------------
   always_comb begin
      dmg_ready_out = (state_q == S_ALIVE);
`ifdef LOW_HP_BLINK_EN
      valid_out     = (((state_q == S_ALIVE) || (state_q == S_CALC)) && blink_q) ||
                      (state_q == S_DYING);
`else
      valid_out     = (state_q == S_ALIVE) || (state_q == S_CALC) || (state_q == S_DYING);
`endif
      border_out    = border_q;
      hp_out        = hp_q;
      defeated_out  = defeated_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_enemy_health_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_enemy_health_ctrl                                       |
// | Description : Self-checking bench for enemy_health_ctrl. Directed       |
// |               scenarios plus a randomized run compared against a        |
// |               frame/cycle behavioural model of the health bar.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_enemy_health_ctrl;

   localparam int MAX_HP     = 100;
   localparam int HP_W       = 8;
   localparam int WIDTH      = 96;
   localparam int DRAIN_STEP = 1;

   localparam int M_IDLE  = 0;
   localparam int M_ALIVE = 1;
   localparam int M_CALC  = 2;
   localparam int M_DYING = 3;
   localparam int M_DEAD  = 4;

   logic            clk_in = 1'b0;
   logic            rst_in = 1'b0;
   logic            new_enemy_in = 1'b0;
   logic            dmg_valid_in = 1'b0;
   logic [HP_W-1:0] dmg_amount_in = '0;
   logic            dmg_ready_out;
   logic            frame_tick_in = 1'b0;
   logic            valid_out;
   logic [10:0]     border_out;
   logic [HP_W-1:0] hp_out;
   logic            defeated_out;

   int errors = 0;
   int checks = 0;

   // Behavioural model
   int m_state, m_hp, m_border, m_target, m_calc_left, m_def;

   enemy_health_ctrl #(
      .MAX_HP(MAX_HP), .HP_W(HP_W), .WIDTH(WIDTH), .DRAIN_STEP(DRAIN_STEP)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .new_enemy_in  (new_enemy_in),
      .dmg_valid_in  (dmg_valid_in),
      .dmg_amount_in (dmg_amount_in),
      .dmg_ready_out (dmg_ready_out),
      .frame_tick_in (frame_tick_in),
      .valid_out     (valid_out),
      .border_out    (border_out),
      .hp_out        (hp_out),
      .defeated_out  (defeated_out)
   );

   always #5 clk_in = ~clk_in;

   // One clock cycle: apply inputs, advance the model at the edge, settle.
   task automatic drive_cycle(input logic r, input logic nw, input logic dv,
                              input logic [HP_W-1:0] amt, input logic tk);
      int nb;
      int gap;
      rst_in        = r;
      new_enemy_in  = nw;
      dmg_valid_in  = dv;
      dmg_amount_in = amt;
      frame_tick_in = tk;
      @(posedge clk_in);
      m_def = 0;
      if (!r) begin
         m_state = M_IDLE; m_hp = 0; m_border = 0; m_target = 0; m_calc_left = 0;
      end else if (nw) begin
         m_state = M_ALIVE; m_hp = MAX_HP; m_border = WIDTH; m_target = WIDTH;
      end else begin
         nb = m_border;
         if (tk && (m_state == M_ALIVE || m_state == M_CALC || m_state == M_DYING)) begin
            gap = m_border - m_target;
            if (gap > 0) nb = m_border - ((gap < DRAIN_STEP) ? gap : DRAIN_STEP);
            else nb = m_target;
         end
         m_border = nb;
         if (m_state == M_ALIVE && dv) begin
            m_hp = (m_hp > int'(amt)) ? m_hp - int'(amt) : 0;
            m_state = M_CALC;
            m_calc_left = 12;
         end else if (m_state == M_CALC) begin
            m_calc_left--;
            if (m_calc_left == 0) begin
               m_target = (m_hp * WIDTH) / MAX_HP;
               m_state = (m_hp > 0) ? M_ALIVE : M_DYING;
            end
         end else if (m_state == M_DYING && tk && nb == 0) begin
            m_state = M_DEAD;
            m_def = 1;
         end
      end
      #1;
      rst_in = 1'b1; new_enemy_in = 1'b0; dmg_valid_in = 1'b0; frame_tick_in = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 1'b0, 1'b1, 8'd5, 1'b1);
         checks++;
         if (dmg_ready_out !== 1'b0) begin
            errors++; $display("FAIL reset_ready_in_reset got=%b exp=0", dmg_ready_out);
         end
      end
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, 1'b0, 1'b1, 8'd5, 1'b1);
         checks++;
         if ({valid_out, dmg_ready_out, defeated_out, border_out, hp_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b r=%b d=%b border=%0d hp=%0d exp all 0",
                     valid_out, dmg_ready_out, defeated_out, border_out, hp_out);
         end
      end
   endtask

   task automatic test_spawn;
      drive_cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
      checks++;
      if (hp_out !== 8'd100 || border_out !== 11'd96 || valid_out !== 1'b1 || dmg_ready_out !== 1'b1) begin
         errors++;
         $display("FAIL spawn got hp=%0d border=%0d v=%b r=%b exp hp=100 border=96 v=1 r=1",
                  hp_out, border_out, valid_out, dmg_ready_out);
      end
   endtask

   task automatic test_damage_25;
      int lows;
      drive_cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b1, 8'd25, 1'b0);
      lows = 0;
      for (int i = 0; i < 40 && dmg_ready_out === 1'b0; i++) begin
         lows++;
         idle(1);
      end
      checks++;
      if (lows != 12) begin
         errors++; $display("FAIL dmg25_calc_cycles got=%0d exp=12", lows);
      end
      checks++;
      if (hp_out !== 8'd75) begin
         errors++; $display("FAIL dmg25_hp got=%0d exp=75", hp_out);
      end
      for (int t = 1; t <= 24; t++) begin
         drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
         idle(2);
         checks++;
         if (border_out !== 11'(96 - t)) begin
            errors++; $display("FAIL dmg25_drain tick=%0d got=%0d exp=%0d", t, border_out, 96 - t);
         end
      end
      drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (border_out !== 11'd72) begin
         errors++; $display("FAIL dmg25_hold got=%0d exp=72", border_out);
      end
   endtask

   task automatic test_damage_67_and_zero;
      int lows;
      drive_cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b1, 8'd67, 1'b0);
      idle(12);
      checks++;
      if (hp_out !== 8'd33 || dmg_ready_out !== 1'b1) begin
         errors++; $display("FAIL dmg67_hp got hp=%0d r=%b exp hp=33 r=1", hp_out, dmg_ready_out);
      end
      for (int i = 0; i < 80; i++) drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (border_out !== 11'd31) begin
         errors++; $display("FAIL dmg67_target got=%0d exp=31", border_out);
      end
      drive_cycle(1'b1, 1'b0, 1'b1, 8'd0, 1'b0);
      lows = 0;
      for (int i = 0; i < 40 && dmg_ready_out === 1'b0; i++) begin
         lows++;
         idle(1);
      end
      checks++;
      if (lows != 12 || hp_out !== 8'd33 || border_out !== 11'd31) begin
         errors++;
         $display("FAIL dmg0 got cycles=%0d hp=%0d border=%0d exp 12/33/31", lows, hp_out, border_out);
      end
   endtask

   task automatic test_death;
      int pulses;
      int first_dead;
      drive_cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b1, 8'd70, 1'b0);
      idle(12);
      drive_cycle(1'b1, 1'b0, 1'b1, 8'd50, 1'b0);
      idle(12);
      checks++;
      if (hp_out !== 8'd0 || valid_out !== 1'b1 || dmg_ready_out !== 1'b0) begin
         errors++;
         $display("FAIL dying_state got hp=%0d v=%b r=%b exp 0/1/0", hp_out, valid_out, dmg_ready_out);
      end
      pulses = 0;
      first_dead = 1;
      for (int i = 0; i < 300 && valid_out === 1'b1; i++) begin
         drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
         if (defeated_out === 1'b1) pulses++;
      end
      checks++;
      if (valid_out !== 1'b0 || border_out !== 11'd0 || defeated_out !== 1'b1) begin
         errors++;
         $display("FAIL dying_drain got v=%b border=%0d def=%b exp 0/0/1", valid_out, border_out, defeated_out);
      end
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b1, 1'b0, 1'b1, 8'd3, 1'b1);
         if (defeated_out === 1'b1) pulses++;
         if (valid_out !== 1'b0 || dmg_ready_out !== 1'b0) first_dead = 0;
      end
      checks++;
      if (pulses != 1) begin
         errors++; $display("FAIL defeated_pulse got=%0d exp=1", pulses);
      end
      checks++;
      if (first_dead != 1 || border_out !== 11'd0 || hp_out !== 8'd0) begin
         errors++; $display("FAIL dead_ignores got border=%0d hp=%0d exp 0/0", border_out, hp_out);
      end
   endtask

   task automatic test_spawn_mid_calc;
      drive_cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
      drive_cycle(1'b1, 1'b0, 1'b1, 8'd40, 1'b0);
      idle(5);
      drive_cycle(1'b1, 1'b1, 1'b1, 8'd50, 1'b1);
      checks++;
      if (hp_out !== 8'd100 || border_out !== 11'd96 || dmg_ready_out !== 1'b1) begin
         errors++;
         $display("FAIL spawn_mid_calc got hp=%0d border=%0d r=%b exp 100/96/1", hp_out, border_out, dmg_ready_out);
      end
      // Spawn together with a live handshake: damage is dropped, no CALC.
      drive_cycle(1'b1, 1'b1, 1'b1, 8'd50, 1'b0);
      checks++;
      if (hp_out !== 8'd100 || dmg_ready_out !== 1'b1) begin
         errors++;
         $display("FAIL spawn_with_accept got hp=%0d r=%b exp 100/1", hp_out, dmg_ready_out);
      end
   endtask

   task automatic test_random;
      logic r, nw, dv, tk;
      logic [HP_W-1:0] amt;
      drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 4000; i++) begin
         r   = ($urandom_range(0, 599) != 0);
         nw  = ($urandom_range(0, 79) == 0);
         dv  = $urandom_range(0, 1) == 1;
         amt = HP_W'($urandom_range(0, 60));
         tk  = ($urandom_range(0, 2) == 0);
         drive_cycle(r, nw, dv, amt, tk);
         checks++;
         if (hp_out !== HP_W'(m_hp) || border_out !== 11'(m_border)) begin
            errors++;
            $display("FAIL rand_data cyc=%0d got hp=%0d border=%0d exp hp=%0d border=%0d",
                     i, hp_out, border_out, m_hp, m_border);
         end
         checks++;
         if (valid_out !== (m_state >= M_ALIVE && m_state <= M_DYING) ||
             dmg_ready_out !== (m_state == M_ALIVE) || defeated_out !== (m_def == 1)) begin
            errors++;
            $display("FAIL rand_ctrl cyc=%0d got v=%b r=%b d=%b exp state=%0d def=%0d",
                     i, valid_out, dmg_ready_out, defeated_out, m_state, m_def);
         end
      end
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_damage_25();
      test_damage_67_and_zero();
      test_death();
      test_spawn_mid_calc();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/enemy_health_ctrl.md
Name: enemy_health_ctrl

Overview:
- Producer side of the enemy health-bar interface: owns enemy hit points, accepts damage events, computes the bar fill width, and drives the renderer's `valid_in` / `border_in` inputs.
- Sits between game logic (hit detection, spawn control) and the health-bar pixel stage.
- Fill width is HP scaled to pixels and divided by MAX_HP with a multicycle divider.
- The displayed width drains toward its target once per video frame.

Parameters:
- MAX_HP, 100, full hit points for a new enemy; must satisfy 1..2^HP_W-1.
- HP_W, 8, width of the HP register and the damage amount.
- WIDTH, 96, bar length in pixels at full HP; must be ≤ 2047.
- DRAIN_STEP, 1, pixels the displayed width moves per frame tick.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-low
- new_enemy_in  input  1  one-cycle pulse; spawn/refill the enemy
- dmg_valid_in  input  1  damage request valid
- dmg_amount_in  input  HP_W  damage amount, unsigned
- dmg_ready_out  output  1  damage can be accepted this cycle
- frame_tick_in  input  1  one-cycle pulse per video frame (end of active area)
- valid_out  output  1  bar visible; drives the renderer's `valid_in`
- border_out  output  11  displayed fill width in pixels; drives the renderer's `border_in`
- hp_out  output  HP_W  current hit points
- defeated_out  output  1  one-cycle pulse when the bar finishes draining to 0

Behaviour:
- **Reset** (rst_in=0 at an edge): state IDLE; hp_out=0, border_out=0, target=0; valid_out=0, dmg_ready_out=0, defeated_out=0.
- **States**
  - IDLE: no enemy.
  - ALIVE: dmg_ready_out=1.
  - CALC: divider running; dmg_ready_out=0.
  - DYING: hp=0, bar draining.
  - DEAD: valid_out=0.
  - valid_out=1 in ALIVE, CALC and DYING.
- **Spawn:** new_enemy_in has priority in every state. Next cycle: hp=MAX_HP, target=WIDTH, border_out=WIDTH (snap, no animation), state ALIVE. Any in-flight CALC is aborted.
- **Damage handshake:** damage is accepted when dmg_valid_in && dmg_ready_out at a clock edge.
  - If new_enemy_in is high in the same cycle, the handshake completes but the damage is discarded.
  - On accept: hp ← hp − amount, saturating at 0. State goes to CALC.
  - Amount 0 is legal and still runs CALC.
- **CALC:** computes target = floor(hp·WIDTH / MAX_HP) with a restoring shift-subtract divider, one quotient bit per cycle, 11 quotient bits.
  - CALC lasts exactly 12 cycles: 1 load + 11 iterations.
  - target updates on the final CALC cycle.
  - Exit to ALIVE if hp>0, otherwise to DYING.
  - dmg_ready_out is high again 12 cycles after the accepting edge.
- **Drain:** applies on frame_tick_in in ALIVE, CALC and DYING.
  - If border_out > target: border_out ← border_out − min(DRAIN_STEP, border_out − target).
  - If border_out < target: snap to target.
  - During CALC the drain continues toward the old target.
  - No change to border_out occurs between frame ticks.
- **DYING:** on the tick where border_out reaches 0, the next cycle pulses defeated_out for exactly 1 cycle and enters DEAD.
  - border_out stays 0 in DEAD.
  - DEAD and IDLE ignore damage and frame ticks and leave only via new_enemy_in.
- **Reset mid-operation:** returns to the reset values immediately; any pending defeated_out pulse is lost.
- **Widths:** the product hp·WIDTH uses HP_W+11 bits; the quotient never exceeds WIDTH.

Optional Feature:
- Macro: LOW_HP_BLINK_EN.
- **Defined:** while state is ALIVE or CALC and hp·4 ≤ MAX_HP, valid_out toggles every 16 frame ticks, using a 4-bit frame counter that is cleared on spawn. valid_out is forced back to 1 when hp rises above the threshold (spawn) or when DYING is entered.
- **Not defined:** valid_out follows state only; the counter is not instantiated.

Test Plan:
- Reset low 3 cycles, then release → all outputs 0, state IDLE; dmg_valid_in=1 never sees dmg_ready_out.
- new_enemy_in pulse → next cycle hp_out=100, border_out=96, valid_out=1, dmg_ready_out=1.
- Damage 25 at full HP → dmg_ready_out low for exactly 12 cycles, hp_out=75, target=72; border_out steps 96→72, one pixel per frame_tick, over 24 ticks.
- Damage 67 from 100 → hp 33, target floor(3168/100)=31; damage 0 → hp unchanged, still 12 CALC cycles.
- hp=30, damage 50 → hp_out=0, DYING, drain to 0; single-cycle defeated_out; valid_out=0 after.
- new_enemy_in mid-CALC with simultaneous dmg_valid_in → hp=100, border_out=96, ALIVE, damage discarded; LOW_HP_BLINK_EN build: hp=25 → valid_out period 32 ticks.
